// File: rtl/knob_button_frontend.sv
// -----------------------------------------------------------------------------
// knob_button_frontend
//   User-input front end for the exposure-meter UI. Decodes a quadrature rotary
//   encoder into detent steps and turns a bouncy active-low pushbutton into a
//   debounced level plus short / medium / long press events for the menu FSM.
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous reset, active high
//   ena        in   block enable; when low all event pulses are suppressed
//   enc_a      in   encoder channel A (asynchronous)
//   enc_b      in   encoder channel B (asynchronous)
//   btn_n      in   pushbutton, active low, asynchronous and bouncy
//   enc_step   out  one-cycle pulse per detent
//   enc_dir    out  direction of the last step, 1 = CW (A leads)
//   enc_err    out  one-cycle pulse when A and B change in the same sample
//   btn_level  out  debounced button level, 1 = pressed
//   btn_short  out  one-cycle pulse on release of a short press
//   btn_medium out  one-cycle pulse on release of a medium press
//   btn_long   out  one-cycle pulse when a press reaches the long threshold
// -----------------------------------------------------------------------------
module knob_button_frontend #(
  parameter int SYNC_STAGES   = 2,
  parameter int STEPS_PER_DET = 4,
  parameter int DIR_INV       = 0,
  parameter int DEB_CYC       = 16,
  parameter int SHORT_MAX     = 200,
  parameter int LONG_CYC      = 600,
  parameter int CNT_W         = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  input  logic enc_a,
  input  logic enc_b,
  input  logic btn_n,
  output logic enc_step,
  output logic enc_dir,
  output logic enc_err,
  output logic btn_level,
  output logic btn_short,
  output logic btn_medium,
  output logic btn_long
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESSED,
    ST_LONG_HELD
  } press_state_e;

  localparam logic signed [3:0] STEP_P  = 4'(STEPS_PER_DET);
  localparam logic signed [3:0] STEP_N  = -STEP_P;
  localparam logic              DIR_BIT = (DIR_INV != 0);
  localparam logic [CNT_W-1:0]  DEB_M1  = CNT_W'(DEB_CYC - 1);
  localparam logic [CNT_W-1:0]  SHORT_T = CNT_W'(SHORT_MAX);
  localparam logic [CNT_W-1:0]  LONG_M1 = CNT_W'(LONG_CYC - 1);

  // Position of an {A,B} sample along the CW Gray sequence 00->10->11->01.
  function automatic logic [1:0] quad_pos(input logic [1:0] ab);
    case (ab)
      2'b00:   quad_pos = 2'd0;
      2'b10:   quad_pos = 2'd1;
      2'b11:   quad_pos = 2'd2;
      default: quad_pos = 2'd3;
    endcase
  endfunction

  // State registers
  logic [SYNC_STAGES-1:0] a_sync_q, b_sync_q, bn_sync_q;
  logic [1:0]             ab_prev_q;
  logic signed [3:0]      acc_q, acc_d;
  logic                   enc_step_q, enc_step_d;
  logic                   enc_dir_q, enc_dir_d;
  logic                   enc_err_q, enc_err_d;
  logic [CNT_W-1:0]       deb_cnt_q, deb_cnt_d;
  logic                   level_q, level_d;
  press_state_e           state_q, state_d;
  logic [CNT_W-1:0]       timer_q, timer_d;
  logic                   short_q, short_d;
  logic                   medium_q, medium_d;
  logic                   long_q, long_d;

  // Combinational helpers
  logic [1:0]        ab_cur;
  logic [1:0]        pos_diff;
  logic signed [3:0] acc_next;
  logic              btn_raw;
  logic              deb_rise, deb_fall;

  assign ab_cur   = {a_sync_q[SYNC_STAGES-1], b_sync_q[SYNC_STAGES-1]};
  assign pos_diff = quad_pos(ab_cur) - quad_pos(ab_prev_q);
  assign btn_raw  = ~bn_sync_q[SYNC_STAGES-1];

  // Encoder: +1 / -1 per legal quarter step, a jump of two positions is an error.
  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    acc_next   = acc_q;
    acc_d      = acc_q;
    enc_step_d = 1'b0;
    enc_dir_d  = enc_dir_q;
    enc_err_d  = 1'b0;
    if (pos_diff == 2'd1) begin
      acc_next = acc_q + 4'sd1;
    end else if (pos_diff == 2'd3) begin
      acc_next = acc_q - 4'sd1;
    end
    if (!ena) begin
      acc_d = '0;
    end else if (pos_diff == 2'd2) begin
      enc_err_d = 1'b1;
    end else if (acc_next == STEP_P) begin
      enc_step_d = 1'b1;
      enc_dir_d  = 1'b1 ^ DIR_BIT;
      acc_d      = '0;
    end else if (acc_next == STEP_N) begin
      enc_step_d = 1'b1;
      enc_dir_d  = 1'b0 ^ DIR_BIT;
      acc_d      = '0;
    end else begin
      acc_d = acc_next;
    end
  end

  // Debouncer: the level only follows the raw input after DEB_CYC consecutive
  // disagreeing samples. The rise/fall strobes feed the press FSM in the same
  // cycle the level register updates.
  always_comb begin
    deb_cnt_d = deb_cnt_q;
    level_d   = level_q;
    deb_rise  = 1'b0;
    deb_fall  = 1'b0;
    if (btn_raw == level_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == DEB_M1) begin
      level_d   = btn_raw;
      deb_cnt_d = '0;
      deb_rise  = btn_raw;
      deb_fall  = ~btn_raw;
    end else if (deb_cnt_q != '1) begin
      deb_cnt_d = deb_cnt_q + 1'b1;
    end
  end

  // Press classifier. The long threshold is tested before the release so a
  // release landing on the threshold cycle reports long only.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    short_d  = 1'b0;
    medium_d = 1'b0;
    long_d   = 1'b0;
    if (!ena) begin
      state_d = ST_IDLE;
      timer_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (deb_rise) begin
            state_d = ST_PRESSED;
            timer_d = '0;
          end
        end
        ST_PRESSED: begin
          if (timer_q != '1) timer_d = timer_q + 1'b1;
          if (timer_q == LONG_M1) begin
            long_d  = 1'b1;
            state_d = deb_fall ? ST_IDLE : ST_LONG_HELD;
          end else if (deb_fall) begin
            state_d = ST_IDLE;
            if (timer_q < SHORT_T) short_d  = 1'b1;
            else                   medium_d = 1'b1;
          end
        end
        ST_LONG_HELD: begin
          if (deb_fall) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge value of every other, independent of statement order.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous; the synchronisers load the idle pin levels
    // (A=0, B=0, button released) so no spurious edge follows reset.
    if (rst) begin
      a_sync_q   <= '0;
      b_sync_q   <= '0;
      bn_sync_q  <= '1;
      ab_prev_q  <= 2'b00;
      acc_q      <= '0;
      enc_step_q <= 1'b0;
      enc_dir_q  <= 1'b0;
      enc_err_q  <= 1'b0;
      deb_cnt_q  <= '0;
      level_q    <= 1'b0;
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      short_q    <= 1'b0;
      medium_q   <= 1'b0;
      long_q     <= 1'b0;
    end else begin
      a_sync_q   <= {a_sync_q[SYNC_STAGES-2:0], enc_a};
      b_sync_q   <= {b_sync_q[SYNC_STAGES-2:0], enc_b};
      bn_sync_q  <= {bn_sync_q[SYNC_STAGES-2:0], btn_n};
      ab_prev_q  <= ab_cur;
      acc_q      <= acc_d;
      enc_step_q <= enc_step_d;
      enc_dir_q  <= enc_dir_d;
      enc_err_q  <= enc_err_d;
      deb_cnt_q  <= deb_cnt_d;
      level_q    <= level_d;
      state_q    <= state_d;
      timer_q    <= timer_d;
      short_q    <= short_d;
      medium_q   <= medium_d;
      long_q     <= long_d;
    end
  end

  assign enc_step   = enc_step_q;
  assign enc_dir    = enc_dir_q;
  assign enc_err    = enc_err_q;
  assign btn_level  = level_q;
  assign btn_short  = short_q;
  assign btn_medium = medium_q;
  assign btn_long   = long_q;

endmodule

// File: tb/tb_knob_button_frontend.sv
// -----------------------------------------------------------------------------
// tb_knob_button_frontend
//   Directed scenarios followed by randomized stimulus. Two instances share the
//   inputs: one with normal direction, one with DIR_INV=1. Every cycle both are
//   compared against a behavioural model built from delay queues, a signed
//   step count, a stable-run counter and a press-age counter.
// -----------------------------------------------------------------------------
module tb_knob_button_frontend;

  localparam int SYNC  = 2;
  localparam int STEPS = 4;
  localparam int DEB   = 16;
  localparam int SHORT = 200;
  localparam int LONG  = 600;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_r = 1'b1;
  logic ena_r = 1'b1;
  logic a_r   = 1'b0;
  logic b_r   = 1'b0;
  logic bn_r  = 1'b1;

  logic enc_step, enc_dir, enc_err, btn_level, btn_short, btn_medium, btn_long;
  logic i_step, i_dir, i_err, i_level, i_short, i_medium, i_long;

  knob_button_frontend #(
    .SYNC_STAGES(SYNC), .STEPS_PER_DET(STEPS), .DIR_INV(0), .DEB_CYC(DEB),
    .SHORT_MAX(SHORT), .LONG_CYC(LONG), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst_r), .ena(ena_r), .enc_a(a_r), .enc_b(b_r), .btn_n(bn_r),
    .enc_step(enc_step), .enc_dir(enc_dir), .enc_err(enc_err), .btn_level(btn_level),
    .btn_short(btn_short), .btn_medium(btn_medium), .btn_long(btn_long)
  );

  knob_button_frontend #(
    .SYNC_STAGES(SYNC), .STEPS_PER_DET(STEPS), .DIR_INV(1), .DEB_CYC(DEB),
    .SHORT_MAX(SHORT), .LONG_CYC(LONG), .CNT_W(16)
  ) dut_inv (
    .clk(clk), .rst(rst_r), .ena(ena_r), .enc_a(a_r), .enc_b(b_r), .btn_n(bn_r),
    .enc_step(i_step), .enc_dir(i_dir), .enc_err(i_err), .btn_level(i_level),
    .btn_short(i_short), .btn_medium(i_medium), .btn_long(i_long)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit [1:0] cw_order [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  function automatic int quad_pos(input bit [1:0] ab);
    for (int i = 0; i < 4; i++) if (cw_order[i] == ab) return i;
    return 0;
  endfunction

  bit [1:0] q_ab [$];
  bit       q_bn [$];
  bit [1:0] m_prev;
  int       m_acc, m_run, m_age;
  bit       m_step, m_dir0, m_dir1, m_err, m_level, m_short, m_med, m_long;
  bit       m_held, m_long_done;

  task automatic model_edge();
    bit [1:0] seen;
    bit       bn_seen, raw, rise, fall;
    int       d;
    m_step = 0; m_err = 0; m_short = 0; m_med = 0; m_long = 0;
    if (rst_r) begin
      q_ab.delete(); q_bn.delete();
      for (int i = 0; i < SYNC; i++) begin q_ab.push_back(2'b00); q_bn.push_back(1'b1); end
      m_prev = 2'b00; m_acc = 0; m_run = 0; m_age = 0;
      m_dir0 = 0; m_dir1 = 0; m_level = 0; m_held = 0; m_long_done = 0;
    end else begin
      q_ab.push_back({a_r, b_r}); seen    = q_ab.pop_front();
      q_bn.push_back(bn_r);       bn_seen = q_bn.pop_front();
      // encoder: distance moved along the CW cycle since the previous sample
      d = (quad_pos(seen) - quad_pos(m_prev) + 4) % 4;
      m_prev = seen;
      if (!ena_r) m_acc = 0;
      else if (d == 2) m_err = 1;
      else if (d != 0) begin
        m_acc += (d == 1) ? 1 : -1;
        if (m_acc == STEPS || m_acc == -STEPS) begin
          m_step = 1;
          m_dir0 = (m_acc > 0);
          m_dir1 = !(m_acc > 0);
          m_acc  = 0;
        end
      end
      // debounce: level follows raw after DEB consecutive disagreeing samples
      raw = !bn_seen; rise = 0; fall = 0;
      if (raw == m_level) m_run = 0;
      else begin
        m_run++;
        if (m_run == DEB) begin m_level = raw; m_run = 0; rise = raw; fall = !raw; end
      end
      // press classification by age (edges since the debounced rise)
      if (!ena_r) m_held = 0;
      else if (!m_held) begin
        if (rise) begin m_held = 1; m_age = 0; m_long_done = 0; end
      end else begin
        m_age++;
        if (!m_long_done && m_age == LONG) begin
          m_long = 1;
          if (fall) m_held = 0; else m_long_done = 1;
        end else if (fall) begin
          m_held = 0;
          if (!m_long_done) begin
            if (m_age - 1 < SHORT) m_short = 1; else m_med = 1;
          end
        end
      end
    end
  endtask

  // ---------------- harness ----------------
  int c_step, c_dir1, c_inv_dir1, c_err, c_short, c_med, c_long, c_rise;
  logic last_level = 1'b0;

  task automatic clear_counts();
    c_step = 0; c_dir1 = 0; c_inv_dir1 = 0; c_err = 0;
    c_short = 0; c_med = 0; c_long = 0; c_rise = 0;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("enc_step",   enc_step,   m_step);
    check("enc_dir",    enc_dir,    m_dir0);
    check("enc_err",    enc_err,    m_err);
    check("btn_level",  btn_level,  m_level);
    check("btn_short",  btn_short,  m_short);
    check("btn_medium", btn_medium, m_med);
    check("btn_long",   btn_long,   m_long);
    check("inv_step",   i_step,     m_step);
    check("inv_dir",    i_dir,      m_dir1);
    check("inv_err",    i_err,      m_err);
    check("inv_level",  i_level,    m_level);
    check("inv_short",  i_short,    m_short);
    check("inv_medium", i_medium,   m_med);
    check("inv_long",   i_long,     m_long);
    if (enc_step === 1'b1) begin c_step++; if (enc_dir === 1'b1) c_dir1++; end
    if (i_step === 1'b1 && i_dir === 1'b1) c_inv_dir1++;
    if (enc_err === 1'b1)    c_err++;
    if (btn_short === 1'b1)  c_short++;
    if (btn_medium === 1'b1) c_med++;
    if (btn_long === 1'b1)   c_long++;
    if (btn_level === 1'b1 && last_level !== 1'b1) c_rise++;
    last_level = btn_level;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic do_reset();
    rst_r = 1'b1; cycle(); rst_r = 1'b0;
  endtask

  task automatic enc_seqs(input bit cw, input int n);
    bit [1:0] seq [4];
    if (cw) seq = '{2'b10, 2'b11, 2'b01, 2'b00};
    else    seq = '{2'b01, 2'b11, 2'b10, 2'b00};
    for (int s = 0; s < n; s++)
      for (int i = 0; i < 4; i++) begin {a_r, b_r} = seq[i]; cycle(); end
  endtask

  task automatic press(input int len, input bit bouncy);
    if (bouncy) begin bn_r = 0; cycle(); bn_r = 1; cycle(); bn_r = 0; cycle(); end
    bn_r = 0; run(len);
    if (bouncy) begin bn_r = 1; cycle(); bn_r = 0; cycle(); bn_r = 1; cycle(); end
    bn_r = 1; run(DEB + SYNC + 8);
  endtask

  initial begin
    int bn_hold;
    clear_counts();

    // reset state
    do_reset();
    check("rst_step",  enc_step,  0);
    check("rst_level", btn_level, 0);
    check("rst_long",  btn_long,  0);
    run(5);

    // 1: four CW detents
    clear_counts();
    enc_seqs(1'b1, 4); run(SYNC + 4);
    check("t1_steps", c_step, 4);
    check("t1_dir1",  c_dir1, 4);
    check("t1_err",   c_err,  0);

    // 2: two CCW detents, inverted instance reports CW, then an illegal jump
    do_reset(); clear_counts();
    enc_seqs(1'b0, 2); run(SYNC + 4);
    check("t2_steps",   c_step,     2);
    check("t2_dir1",    c_dir1,     0);
    check("t2_inv_dir", c_inv_dir1, 2);
    {a_r, b_r} = 2'b11; run(SYNC + 4);
    check("t2_err",     c_err,  1);
    check("t2_steps_b", c_step, 2);

    // 3: bouncy 100-cycle press
    do_reset(); {a_r, b_r} = 2'b00; run(SYNC + 2); clear_counts();
    press(100, 1'b1);
    check("t3_short", c_short, 1);
    check("t3_med",   c_med,   0);
    check("t3_rise",  c_rise,  1);
    check("t3_level", btn_level, 0);

    // 4: medium and long presses
    clear_counts();
    press(400, 1'b0);
    check("t4_med",   c_med,   1);
    check("t4_short", c_short, 0);
    clear_counts();
    press(700, 1'b0);
    check("t4_long",  c_long,  1);
    check("t4_med_b", c_med,   0);
    check("t4_sh_b",  c_short, 0);

    // 5: press begun while disabled produces nothing
    clear_counts();
    ena_r = 0; bn_r = 0; run(60);
    ena_r = 1; run(60);
    bn_r = 1; run(40);
    press(100, 1'b0);
    check("t5_short", c_short, 1);
    check("t5_med",   c_med,   0);
    check("t5_long",  c_long,  0);

    // 6: reset mid-rotation (acc=3) and mid-press (T~300)
    {a_r, b_r} = 2'b10; cycle(); {a_r, b_r} = 2'b11; cycle(); {a_r, b_r} = 2'b01; cycle();
    run(SYNC + 4);
    bn_r = 0; run(SYNC + DEB + 300);
    clear_counts();
    bn_r = 1; {a_r, b_r} = 2'b00; do_reset(); run(40);
    check("t6_step",  c_step, 0);
    check("t6_press", c_short + c_med + c_long, 0);
    enc_seqs(1'b1, 1); run(SYNC + 4);
    check("t6_step_b", c_step, 1);
    check("t6_err",    c_err,  0);

    // randomized stimulus
    bn_hold = 0;
    for (int k = 0; k < 8000; k++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 25)      {a_r, b_r} = cw_order[(quad_pos({a_r, b_r}) + 1) % 4];
      else if (r < 50) {a_r, b_r} = cw_order[(quad_pos({a_r, b_r}) + 3) % 4];
      else if (r < 53) {a_r, b_r} = ~{a_r, b_r};
      if (bn_hold == 0) begin
        bn_r    = ~bn_r;
        bn_hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : $urandom_range(20, 800);
      end
      bn_hold--;
      if (ena_r && $urandom_range(0, 599) == 0) ena_r = 0;
      else if (!ena_r && $urandom_range(0, 39) == 0) ena_r = 1;
      rst_r = ($urandom_range(0, 1999) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
